// File: rtl/booth_mult_core.sv
// Radix-2 Booth sequential multiplier: two-cycle operand load, BUS_WIDTH
// EVAL/SHIFT iterations, then product streamed high byte first on outbus.
module booth_mult_core #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] inbus,
    input  logic                 beginsig,
    input  logic                 locksig,
    output logic [BUS_WIDTH-1:0] outbus,
    output logic                 endsig
);

    localparam int CW = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_Q,
        S_EVAL,
        S_SHIFT,
        S_OUT_HI,
        S_OUT_LO,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [BUS_WIDTH:0]   m_q, m_d;
    logic [BUS_WIDTH:0]   a_q, a_d;
    logic [BUS_WIDTH-1:0] q_q, q_d;
    logic                 q1_q, q1_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        if (!locksig) begin
            unique case (state_q)
                S_IDLE: begin
                    if (beginsig) begin
                        m_d     = {inbus[BUS_WIDTH-1], inbus};
                        a_d     = '0;
                        cnt_d   = '0;
                        state_d = S_LOAD_Q;
                    end
                end
                S_LOAD_Q: begin
                    q_d     = inbus;
                    q1_d    = 1'b0;
                    state_d = S_EVAL;
                end
                S_EVAL: begin
                    unique case ({q_q[0], q1_q})
                        2'b01:   a_d = a_q + m_q;
                        2'b10:   a_d = a_q - m_q;
                        default: a_d = a_q;
                    endcase
                    state_d = S_SHIFT;
                end
                S_SHIFT: begin
                    // Arithmetic right shift of the {A,Q,Q_1} chain; old Q_1 falls off.
                    {a_d, q_d, q1_d} = {a_q[BUS_WIDTH], a_q, q_q};
                    cnt_d            = cnt_q + CW'(1);
                    state_d          = (cnt_q == CW'(BUS_WIDTH - 1)) ? S_OUT_HI : S_EVAL;
                end
                S_OUT_HI: state_d = S_OUT_LO;
                S_OUT_LO: state_d = S_DONE;
                S_DONE: begin
                    if (!beginsig) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        outbus = '0;
        if (state_q == S_OUT_HI) begin
            outbus = a_q[BUS_WIDTH-1:0];
        end else if (state_q == S_OUT_LO) begin
            outbus = q_q;
        end
        endsig = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_booth_mult_core.sv
// Self-checking bench for booth_mult_core: cycle-phase reference model with a
// per-cycle compare, plus directed operations with hand-computed products.
module tb_booth_mult_core;

    logic       clk;
    logic       reset;
    logic [7:0] inbus;
    logic       beginsig;
    logic       locksig;
    logic [7:0] outbus;
    logic       endsig;

    int n_pass  = 0;
    int n_total = 0;

    booth_mult_core #(.BUS_WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .inbus    (inbus),
        .beginsig (beginsig),
        .locksig  (locksig),
        .outbus   (outbus),
        .endsig   (endsig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the cycle index since the start edge (k), which
    // advances on every unstalled edge; outputs follow purely from k and the product.
    logic               mdl_active;
    int                 mdl_k;
    logic signed [7:0]  mdl_a;
    logic signed [15:0] mdl_prod;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mdl_active = 1'b0;
            mdl_k      = 0;
        end else if (!locksig) begin
            if (!mdl_active) begin
                if (beginsig) begin
                    mdl_active = 1'b1;
                    mdl_k      = 1;
                    mdl_a      = $signed(inbus);
                end
            end else if (mdl_k < 20) begin
                if (mdl_k == 1) begin
                    mdl_prod = mdl_a * $signed(inbus);
                end
                mdl_k++;
            end else if (!beginsig) begin
                mdl_active = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] exp_out;
        logic       exp_end;
        exp_out = 8'h00;
        if (mdl_active && mdl_k == 18) exp_out = mdl_prod[15:8];
        if (mdl_active && mdl_k == 19) exp_out = mdl_prod[7:0];
        exp_end = mdl_active && (mdl_k == 20);
        check("model_outbus", {8'h00, outbus}, {8'h00, exp_out});
        check("model_endsig", {15'h0, endsig}, {15'h0, exp_end});
    end

    // One multiply with beginsig held high throughout, optional stall window,
    // junk on inbus after the operands, and literal product expectations.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ehi, input logic [7:0] elo,
                          input int stall_at, input int stall_len, input string name);
        int c;
        int hi_cyc;
        hi_cyc = 18 + stall_len;
        @(negedge clk);
        beginsig = 1'b1;
        locksig  = 1'b0;
        inbus    = a;
        @(negedge clk);
        c     = 1;
        inbus = b;
        while (c < hi_cyc) begin
            if (c >= 2) inbus = 8'($urandom);
            locksig = (stall_len > 0) && (c >= stall_at) && (c < stall_at + stall_len);
            @(negedge clk);
            c++;
            if (c == hi_cyc - 1) begin
                check({name, "_pre_hi"}, {7'h0, endsig, outbus}, 16'h0000);
            end
        end
        locksig = 1'b0;
        check({name, "_hi"}, {8'h00, outbus}, {8'h00, ehi});
        @(negedge clk);
        check({name, "_lo"}, {8'h00, outbus}, {8'h00, elo});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({name, "_done"}, {7'h0, endsig, outbus}, 16'h0100);
        end
        beginsig = 1'b0;
        @(negedge clk);
        check({name, "_idle"}, {7'h0, endsig, outbus}, 16'h0000);
    endtask

    initial begin
        reset    = 1'b1;
        inbus    = 8'h00;
        beginsig = 1'b0;
        locksig  = 1'b0;
        #1;
        check("reset_out", {7'h0, endsig, outbus}, 16'h0000);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_op(8'h03, 8'h05, 8'h00, 8'h0F, 0, 0, "p3x5");
        run_op(8'hFD, 8'h05, 8'hFF, 8'hF1, 0, 0, "m3x5");
        run_op(8'h7F, 8'h7F, 8'h3F, 8'h01, 0, 0, "p127sq");
        run_op(8'h80, 8'h80, 8'h40, 8'h00, 0, 0, "m128sq");
        run_op(8'h00, 8'h9C, 8'h00, 8'h00, 0, 0, "zero");
        run_op(8'h7F, 8'h80, 8'hC0, 8'h80, 6, 5, "stall");

        // Abort during the SHIFT of iteration 4 (cycle 9 after the start edge).
        @(negedge clk);
        beginsig = 1'b1;
        inbus    = 8'h55;
        @(negedge clk);
        inbus    = 8'h33;
        beginsig = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_out", {7'h0, endsig, outbus}, 16'h0000);
        @(negedge clk);
        check("abort_hold", {7'h0, endsig, outbus}, 16'h0000);
        reset = 1'b0;
        repeat (25) begin
            @(negedge clk);
            check("abort_quiet", {7'h0, endsig, outbus}, 16'h0000);
        end

        run_op(8'h06, 8'hF9, 8'hFF, 8'hD6, 0, 0, "p6xm7");

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
